// File: rtl/lda_arb_pkg.sv
// Shared types and default widths for the line-drawing-engine arbiter.
package lda_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int X_W_DEF   = 9;
  localparam int Y_W_DEF   = 8;
  localparam int COL_W_DEF = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester above last_grant wins,
// wrapping around, so the most recent winner has the lowest priority.
module rr_arbiter
  import lda_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] w_idx;

  // Scan last_grant+1, last_grant+2, ... (mod N_REQ) and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/lda_arbiter.sv
// Shares one line-drawing engine between N_REQ requesters: round-robin grant,
// operand latch, start pulse, wait for done, completion pulse to the owner.
module lda_arbiter
  import lda_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int COL_W = COL_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*X_W-1:0]       i_x0,
  input  logic [N_REQ*X_W-1:0]       i_x1,
  input  logic [N_REQ*Y_W-1:0]       i_y0,
  input  logic [N_REQ*Y_W-1:0]       i_y1,
  input  logic [N_REQ*COL_W-1:0]     i_col,
  output logic [N_REQ-1:0]           o_ack,
  output logic [N_REQ-1:0]           o_done,
  output logic                       o_busy,
  output logic [$clog2(N_REQ)-1:0]   o_owner,
  output logic [X_W-1:0]             o_x0,
  output logic [X_W-1:0]             o_x1,
  output logic [Y_W-1:0]             o_y0,
  output logic [Y_W-1:0]             o_y1,
  output logic [COL_W-1:0]           o_col,
  output logic                       o_start,
  input  logic                       i_done
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       r_state, w_stateNext;
  logic [IDX_W-1:0] r_lastGrant, r_owner, w_grantIdx;
  logic [N_REQ-1:0] w_grant, r_ack, r_done;
  logic             w_any, r_start;
  logic [X_W-1:0]   r_x0, r_x1, w_x0, w_x1;
  logic [Y_W-1:0]   r_y0, r_y1, w_y0, w_y1;
  logic [COL_W-1:0] r_col, w_col;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (i_req),
    .last_grant (r_lastGrant),
    .grant      (w_grant),
    .grant_idx  (w_grantIdx),
    .any        (w_any)
  );

  // Select the winning requester's operand slices ahead of the grant edge.
  always_comb begin
    w_x0  = '0;
    w_x1  = '0;
    w_y0  = '0;
    w_y1  = '0;
    w_col = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grantIdx == IDX_W'(k)) begin
        w_x0  = i_x0[k*X_W +: X_W];
        w_x1  = i_x1[k*X_W +: X_W];
        w_y0  = i_y0[k*Y_W +: Y_W];
        w_y1  = i_y1[k*Y_W +: Y_W];
        w_col = i_col[k*COL_W +: COL_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: i_done only counts once the start pulse has gone out.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:      if (w_any) w_stateNext = S_START;
      S_START:     w_stateNext = S_WAIT_DONE;
      S_WAIT_DONE: if (i_done) w_stateNext = S_IDLE;
      default:     w_stateNext = S_IDLE;
    endcase
  end

  // Registered pulses, owner tracking and operand latch, all glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastGrant <= IDX_W'(N_REQ - 1);
      r_owner     <= '0;
      r_start     <= 1'b0;
      r_ack       <= '0;
      r_done      <= '0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_col       <= '0;
    end else begin
      r_start <= 1'b0;
      r_ack   <= '0;
      r_done  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_lastGrant <= w_grantIdx;
            r_owner     <= w_grantIdx;
            r_start     <= 1'b1;
            r_ack       <= w_grant;
            r_x0        <= w_x0;
            r_x1        <= w_x1;
            r_y0        <= w_y0;
            r_y1        <= w_y1;
            r_col       <= w_col;
          end
        end
        S_WAIT_DONE: begin
          if (i_done) r_done[r_owner] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_start = r_start;
  assign o_ack   = r_ack;
  assign o_done  = r_done;
  assign o_owner = r_owner;
  assign o_x0    = r_x0;
  assign o_x1    = r_x1;
  assign o_y0    = r_y0;
  assign o_y1    = r_y1;
  assign o_col   = r_col;

endmodule
